pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central hazard controller for the five-stage pipeline. It computes the per-stage stall/flush controls that drive the F/D/E/M/W pipeline registers, and the operand-forwarding selects for decode and execute. It sequences multi-cycle divides with a cycle counter and handles exception flush while an instruction fetch is still outstanding. It sits beside the datapath and drives the `hazard_intf` bundle.

## Interface
- `DIV_CYCLES`, 32: total cycles the divide instruction occupies E (≥2).
- `clk` in 1: pipeline clock.
- `resetn` in 1: synchronous, active-low reset.
- `rsD`, `rtD` in 5 each: source registers of the instruction in D.
- `branchD` in 1: D instruction resolves a branch in D and needs its operands there.
- `rsE`, `rtE`, `writeregE` in 5 each: E source and destination registers.
- `regwriteE`, `memtoregE` in 1 each: E writes a register; E is a load.
- `writeregM` in 5; `regwriteM`, `memtoregM` in 1 each: the same fields for M.
- `writeregW` in 5; `regwriteW` in 1: the same fields for W.
- `div_startE` in 1: a divide is in E.
- `imem_stall` in 1: instruction fetch not yet returned.
- `dmem_stall` in 1: data access in M not yet returned.
- `exceptionM` in 1: the instruction in M raised an exception.
- `stallF`, `stallD`, `stallE`, `stallM` out 1 each: hold the corresponding stage register.
- `flushD`, `flushE`, `flushM`, `flushW` out 1 each: load a bubble into the corresponding stage register.
- `forwardAE`, `forwardBE` out 2 each: E operand select. 2'b10 selects M, 2'b01 selects W, 2'b00 selects the register file.
- `forwardAD`, `forwardBD` out 1 each: D operand takes the M result.
- `div_busy` out 1: a divide is occupying E.

## Operation
- **State:** FSM states IDLE, DIV, EXC_WAIT, plus a `$clog2(DIV_CYCLES)`-bit down-counter `cnt`.
- **Outputs:** all outputs are combinational from the inputs, `state` and `cnt`.
- **Forwarding:** a match requires the stage's regwrite bit set and writereg ≠ 0.
  - For E operands, M has priority over W.
  - D forwarding uses M only.
- **Load-use hazard (`lw`):** `memtoregE & regwriteE & writeregE≠0 & (writeregE==rsD | writeregE==rtD)`.
- **Branch hazard (`br`):** `branchD`, and either
  - E writes rsD or rtD (nonzero destination), or
  - M is a load whose writeregM is nonzero and equals rsD or rtD.
- **Divide stall (`dv`):** `(state==IDLE & div_startE) | (state==DIV & cnt≠0)`.
- **Stall chain:** the outermost cause determines how far back the stall reaches, and every stage upstream of it is also stalled.
  - `dmem_stall`: stall F, D, E, M and flushW.
  - else `dv`: stall F, D, E and flushM.
  - else `lw | br`: stall F, D and flushE.
  - else `imem_stall`: stallF and flushD.
- **Stall/flush exclusivity:** a flush is never asserted on a stalled stage, and a stalled stage never has its flush asserted.
- **Exception** (`exceptionM`, highest priority):
  - flushD, flushE, flushM and flushW asserted; all stalls deasserted, so F loads the vector PC.
  - Any divide is aborted: state goes to IDLE and `cnt` to 0.
  - If `imem_stall` is also 1, the next state is EXC_WAIT instead.
- **EXC_WAIT:**
  - flushD is asserted every cycle; stallF = `imem_stall`.
  - Exit to IDLE on the first cycle with `imem_stall==0`; flushD is still asserted in that cycle, discarding the wrong-path instruction.
  - `dmem_stall`, `lw`, `br` and `dv` are ignored in this state.
- **DIV sequencing:**
  - IDLE → DIV when `div_startE` is seen and neither `exceptionM` nor `dmem_stall` is set; `cnt` loads DIV_CYCLES−1.
  - In DIV, `cnt` decrements each cycle while nonzero, including under `dmem_stall`.
  - DIV → IDLE when `cnt==0 & ~dmem_stall`.
  - `div_startE` is ignored while in DIV.
- **div_busy:** `(state==DIV) | (state==IDLE & div_startE)`.
- **Reset:** `resetn` low at a clock edge puts state in IDLE and `cnt` at 0. While `resetn` is low:
  - all stalls are 0 and all flushes are 1;
  - forward selects are 0 and `div_busy` is 0.
  - Reset mid-divide or in EXC_WAIT abandons the operation.

## Timing
- Zero-latency controls: stall, flush and forward outputs respond in the same cycle as their inputs.
- A load-use hazard inserts exactly 1 bubble into E.
- A divide holds E for exactly DIV_CYCLES cycles when no `dmem_stall` occurs. Each `dmem_stall` cycle after `cnt` reaches 0 adds one cycle.
- An exception takes effect in 1 cycle.
- EXC_WAIT lasts until fetch return, with no upper bound.

## Test plan
- **Load-use:** `lw r5` in E (regwriteE=1, memtoregE=1, writeregE=5), rsD=5 → stallF=stallD=1, flushE=1 for 1 cycle. With writeregE=0 → no stall.
- **Forward priority:** regwriteM=1, writeregM=3, regwriteW=1, writeregW=3, rsE=3 → forwardAE=2'b10. Clear regwriteM → 2'b01.
- **Divide, DIV_CYCLES=4:** div_startE held → stallE=1 and flushM=1 for exactly 4 cycles, then 0. div_busy tracks this. Insert dmem_stall in cycle 2 → stallM=1 and flushW=1 for that cycle; total E hold is still 4 cycles.
- **Exception in DIV with imem_stall=1:** flushD/E/M/W=1 and stalls=0 in the exception cycle. Next cycle the state is EXC_WAIT: flushD=1 and stallF=1 until imem_stall drops, including the drop cycle; the cycle after that, flushD=0.
- **Reset mid-divide:** resetn=0 for 1 cycle during DIV → all flushes=1 and stalls=0 during reset. After reset, div_busy=0, and a new div_startE yields a full DIV_CYCLES hold.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard control bundle between the pipeline datapath and the central hazard
// controller. The datapath reports register usage and memory/exception status.
// The controller returns per-stage stall/flush controls and forwarding selects.
interface hazard_intf;
    // Decode stage
    logic [4:0] rsD;
    logic [4:0] rtD;
    logic       branchD;
    // Execute stage
    logic [4:0] rsE;
    logic [4:0] rtE;
    logic [4:0] writeregE;
    logic       regwriteE;
    logic       memtoregE;
    logic       div_startE;
    // Memory stage
    logic [4:0] writeregM;
    logic       regwriteM;
    logic       memtoregM;
    logic       exceptionM;
    // Writeback stage
    logic [4:0] writeregW;
    logic       regwriteW;
    // Memory system status
    logic       imem_stall;
    logic       dmem_stall;
    // Controls returned to the datapath
    logic       stallF;
    logic       stallD;
    logic       stallE;
    logic       stallM;
    logic       flushD;
    logic       flushE;
    logic       flushM;
    logic       flushW;
    logic [1:0] forwardAE;
    logic [1:0] forwardBE;
    logic       forwardAD;
    logic       forwardBD;
    logic       div_busy;

    // Hazard controller side
    modport master (
        input  rsD, rtD, branchD,
        input  rsE, rtE, writeregE, regwriteE, memtoregE, div_startE,
        input  writeregM, regwriteM, memtoregM, exceptionM,
        input  writeregW, regwriteW,
        input  imem_stall, dmem_stall,
        output stallF, stallD, stallE, stallM,
        output flushD, flushE, flushM, flushW,
        output forwardAE, forwardBE, forwardAD, forwardBD,
        output div_busy
    );

    // Datapath side
    modport slave (
        output rsD, rtD, branchD,
        output rsE, rtE, writeregE, regwriteE, memtoregE, div_startE,
        output writeregM, regwriteM, memtoregM, exceptionM,
        output writeregW, regwriteW,
        output imem_stall, dmem_stall,
        input  stallF, stallD, stallE, stallM,
        input  flushD, flushE, flushM, flushW,
        input  forwardAE, forwardBE, forwardAD, forwardBD,
        input  div_busy
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller for the five-stage F/D/E/M/W pipeline.
// It generates stall/flush controls and operand forwarding selects.
// It sequences multi-cycle divides with a down-counter.
// On an exception it flushes the pipeline and waits in EXC_WAIT for an
// outstanding instruction fetch to return.
module pipe_hazard_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       resetn,
    hazard_intf.master hz
);

    localparam int CNT_W = $clog2(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DIV      = 2'd1,
        S_EXC_WAIT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic       w_lw;
    logic       w_br;
    logic       w_dv;
    logic       w_e_hits_d;
    logic       w_m_hits_d;
    logic [1:0] w_fwd_ae;
    logic [1:0] w_fwd_be;
    logic       w_fwd_ad;
    logic       w_fwd_bd;

    // Hazard detection and forwarding match logic; M wins over W for E operands
    always_comb begin
        w_e_hits_d = hz.regwriteE && (hz.writeregE != 5'd0) &&
                     ((hz.writeregE == hz.rsD) || (hz.writeregE == hz.rtD));
        w_m_hits_d = hz.memtoregM && (hz.writeregM != 5'd0) &&
                     ((hz.writeregM == hz.rsD) || (hz.writeregM == hz.rtD));
        w_lw = hz.memtoregE && w_e_hits_d;
        w_br = hz.branchD && (w_e_hits_d || w_m_hits_d);
        w_dv = ((r_state == S_IDLE) && hz.div_startE) ||
               ((r_state == S_DIV) && (r_cnt != '0));

        w_fwd_ae = 2'b00;
        if (hz.regwriteM && (hz.writeregM != 5'd0) && (hz.writeregM == hz.rsE))
            w_fwd_ae = 2'b10;
        else if (hz.regwriteW && (hz.writeregW != 5'd0) && (hz.writeregW == hz.rsE))
            w_fwd_ae = 2'b01;

        w_fwd_be = 2'b00;
        if (hz.regwriteM && (hz.writeregM != 5'd0) && (hz.writeregM == hz.rtE))
            w_fwd_be = 2'b10;
        else if (hz.regwriteW && (hz.writeregW != 5'd0) && (hz.writeregW == hz.rtE))
            w_fwd_be = 2'b01;

        w_fwd_ad = hz.regwriteM && (hz.writeregM != 5'd0) && (hz.writeregM == hz.rsD);
        w_fwd_bd = hz.regwriteM && (hz.writeregM != 5'd0) && (hz.writeregM == hz.rtD);
    end

    // Next-state and divide counter; an exception aborts any divide in progress
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (hz.exceptionM) begin
            w_state_nxt = hz.imem_stall ? S_EXC_WAIT : S_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (hz.div_startE && !hz.dmem_stall) begin
                        w_state_nxt = S_DIV;
                        w_cnt_nxt   = CNT_LOAD;
                    end
                end
                S_DIV: begin
                    // The counter keeps running under dmem_stall; only the exit waits
                    if (r_cnt != '0)
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    else if (!hz.dmem_stall)
                        w_state_nxt = S_IDLE;
                end
                S_EXC_WAIT: begin
                    if (!hz.imem_stall)
                        w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Stall/flush controls: exception first, then EXC_WAIT, then the outermost stall cause
    always_comb begin
        hz.stallF    = 1'b0;
        hz.stallD    = 1'b0;
        hz.stallE    = 1'b0;
        hz.stallM    = 1'b0;
        hz.flushD    = 1'b0;
        hz.flushE    = 1'b0;
        hz.flushM    = 1'b0;
        hz.flushW    = 1'b0;
        hz.forwardAE = 2'b00;
        hz.forwardBE = 2'b00;
        hz.forwardAD = 1'b0;
        hz.forwardBD = 1'b0;
        hz.div_busy  = 1'b0;
        if (!resetn) begin
            hz.flushD = 1'b1;
            hz.flushE = 1'b1;
            hz.flushM = 1'b1;
            hz.flushW = 1'b1;
        end else begin
            hz.forwardAE = w_fwd_ae;
            hz.forwardBE = w_fwd_be;
            hz.forwardAD = w_fwd_ad;
            hz.forwardBD = w_fwd_bd;
            hz.div_busy  = (r_state == S_DIV) || ((r_state == S_IDLE) && hz.div_startE);
            if (hz.exceptionM) begin
                // All stalls released so F loads the exception vector
                hz.flushD = 1'b1;
                hz.flushE = 1'b1;
                hz.flushM = 1'b1;
                hz.flushW = 1'b1;
            end else if (r_state == S_EXC_WAIT) begin
                // The wrong-path fetch is discarded, including on the return cycle
                hz.flushD = 1'b1;
                hz.stallF = hz.imem_stall;
            end else if (hz.dmem_stall) begin
                hz.stallF = 1'b1;
                hz.stallD = 1'b1;
                hz.stallE = 1'b1;
                hz.stallM = 1'b1;
                hz.flushW = 1'b1;
            end else if (w_dv) begin
                hz.stallF = 1'b1;
                hz.stallD = 1'b1;
                hz.stallE = 1'b1;
                hz.flushM = 1'b1;
            end else if (w_lw || w_br) begin
                hz.stallF = 1'b1;
                hz.stallD = 1'b1;
                hz.flushE = 1'b1;
            end else if (hz.imem_stall) begin
                hz.stallF = 1'b1;
                hz.flushD = 1'b1;
            end
        end
    end

    // State and counter registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with DIV_CYCLES = 4.
// Each step queues its expected control vector, then checks it at the negedge.
// Vector layout: {stallF,D,E,M, flushD,E,M,W, fwdAE, fwdBE, fwdAD, fwdBD, div_busy}
module tb_pipe_hazard_ctrl;

    logic clk;
    logic resetn;
    int   n_err;
    int   n_checks;

    logic [14:0] q_exp[$];
    string       q_tag[$];

    hazard_intf hif();

    pipe_hazard_ctrl #(.DIV_CYCLES(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .hz     (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] ev(input logic [3:0] st, input logic [3:0] fl,
                                       input logic [1:0] ae, input logic [1:0] be,
                                       input logic ad, input logic bd, input logic bz);
        return {st, fl, ae, be, ad, bd, bz};
    endfunction

    task automatic clr();
        hif.rsD = 5'd0; hif.rtD = 5'd0; hif.branchD = 1'b0;
        hif.rsE = 5'd0; hif.rtE = 5'd0; hif.writeregE = 5'd0;
        hif.regwriteE = 1'b0; hif.memtoregE = 1'b0; hif.div_startE = 1'b0;
        hif.writeregM = 5'd0; hif.regwriteM = 1'b0; hif.memtoregM = 1'b0;
        hif.exceptionM = 1'b0;
        hif.writeregW = 5'd0; hif.regwriteW = 1'b0;
        hif.imem_stall = 1'b0; hif.dmem_stall = 1'b0;
    endtask

    task automatic step(input string tag, input logic [14:0] e);
        logic [14:0] obs;
        logic [14:0] want;
        string       t;
        q_exp.push_back(e);
        q_tag.push_back(tag);
        @(negedge clk);
        obs = {hif.stallF, hif.stallD, hif.stallE, hif.stallM,
               hif.flushD, hif.flushE, hif.flushM, hif.flushW,
               hif.forwardAE, hif.forwardBE, hif.forwardAD, hif.forwardBD,
               hif.div_busy};
        want = q_exp.pop_front();
        t    = q_tag.pop_front();
        n_checks++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: got %b expected %b", t, obs, want);
        end
        @(posedge clk);
        #1;
    endtask

    logic [14:0] Z, DV, DM, BZ;

    initial begin
        n_err    = 0;
        n_checks = 0;
        Z  = ev(4'b0000, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        DV = ev(4'b1110, 4'b0010, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        DM = ev(4'b1111, 4'b0001, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        BZ = ev(4'b0000, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);

        clr();
        resetn = 1'b0;
        @(posedge clk);
        #1;
        // Reset: flushes high, stalls low, forwarding and busy masked
        hif.rsE = 5'd3; hif.regwriteM = 1'b1; hif.writeregM = 5'd3; hif.div_startE = 1'b1;
        step("reset_out", ev(4'b0000, 4'b1111, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
        resetn = 1'b1;
        clr();
        step("idle", Z);

        // Load-use: exactly one bubble, then D forwards from M
        hif.regwriteE = 1'b1; hif.memtoregE = 1'b1; hif.writeregE = 5'd5; hif.rsD = 5'd5;
        step("lw_stall", ev(4'b1100, 4'b0100, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
        clr();
        hif.regwriteM = 1'b1; hif.memtoregM = 1'b1; hif.writeregM = 5'd5; hif.rsD = 5'd5;
        step("lw_after", ev(4'b0000, 4'b0000, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0));
        clr();
        hif.regwriteE = 1'b1; hif.memtoregE = 1'b1; hif.writeregE = 5'd0; hif.rsD = 5'd0;
        step("lw_r0", Z);

        // Forward priority for E operands
        clr();
        hif.regwriteM = 1'b1; hif.writeregM = 5'd3; hif.regwriteW = 1'b1; hif.writeregW = 5'd3;
        hif.rsE = 5'd3; hif.rtE = 5'd3;
        step("fwd_m_prio", ev(4'b0000, 4'b0000, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0));
        hif.regwriteM = 1'b0;
        step("fwd_w", ev(4'b0000, 4'b0000, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0));
        hif.rtE = 5'd7;
        step("fwd_b_none", ev(4'b0000, 4'b0000, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0));
        hif.rsE = 5'd0; hif.rtE = 5'd0; hif.writeregW = 5'd0;
        step("fwd_r0", Z);

        // Branch hazards
        clr();
        hif.branchD = 1'b1; hif.rsD = 5'd4; hif.regwriteE = 1'b1; hif.writeregE = 5'd4;
        step("br_e", ev(4'b1100, 4'b0100, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
        clr();
        hif.branchD = 1'b1; hif.rtD = 5'd6; hif.memtoregM = 1'b1; hif.regwriteM = 1'b1;
        hif.writeregM = 5'd6;
        step("br_mload", ev(4'b1100, 4'b0100, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0));
        hif.memtoregM = 1'b0;
        step("br_malu", ev(4'b0000, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0));

        // Instruction fetch stall alone
        clr();
        hif.imem_stall = 1'b1;
        step("imem", ev(4'b1000, 4'b1000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));

        // Divide with a dmem stall mid-way: E still held 4 cycles
        clr();
        hif.div_startE = 1'b1;
        step("div_c0", DV);
        step("div_c1", DV);
        hif.dmem_stall = 1'b1;
        step("div_c2_dmem", DM);
        hif.dmem_stall = 1'b0;
        step("div_c3", DV);
        step("div_done", BZ);
        hif.div_startE = 1'b0;
        step("div_idle", Z);

        // Divide with dmem stall after the count expires: one extra cycle
        hif.div_startE = 1'b1;
        step("div2_c0", DV);
        step("div2_c1", DV);
        step("div2_c2", DV);
        step("div2_c3", DV);
        hif.dmem_stall = 1'b1;
        step("div2_ext", DM);
        hif.dmem_stall = 1'b0;
        step("div2_done", BZ);
        hif.div_startE = 1'b0;
        step("div2_idle", Z);

        // Exception during divide with fetch outstanding
        hif.div_startE = 1'b1;
        step("exc_div_c0", DV);
        hif.exceptionM = 1'b1; hif.imem_stall = 1'b1;
        step("exc_cycle", ev(4'b0000, 4'b1111, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1));
        hif.exceptionM = 1'b0; hif.dmem_stall = 1'b1;
        hif.regwriteE = 1'b1; hif.memtoregE = 1'b1; hif.writeregE = 5'd5; hif.rsD = 5'd5;
        step("excw_1", ev(4'b1000, 4'b1000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
        step("excw_2", ev(4'b1000, 4'b1000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
        hif.imem_stall = 1'b0;
        step("excw_ret", ev(4'b0000, 4'b1000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
        clr();
        step("excw_after", Z);

        // Exception overrides dmem and load-use stalls, no fetch outstanding
        hif.exceptionM = 1'b1; hif.dmem_stall = 1'b1;
        hif.regwriteE = 1'b1; hif.memtoregE = 1'b1; hif.writeregE = 5'd5; hif.rsD = 5'd5;
        step("exc_prio", ev(4'b0000, 4'b1111, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
        clr();
        step("exc_after", Z);

        // Reset mid-divide abandons it; a new divide gets a full hold
        hif.div_startE = 1'b1;
        step("rdiv_c0", DV);
        step("rdiv_c1", DV);
        resetn = 1'b0;
        step("rdiv_reset", ev(4'b0000, 4'b1111, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
        resetn = 1'b1;
        hif.div_startE = 1'b0;
        step("rdiv_post", Z);
        hif.div_startE = 1'b1;
        step("ndiv_c0", DV);
        step("ndiv_c1", DV);
        step("ndiv_c2", DV);
        step("ndiv_c3", DV);
        step("ndiv_done", BZ);
        hif.div_startE = 1'b0;
        step("ndiv_idle", Z);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
